// File: rtl/matvec_n_if.sv
// Stream bundle for matvec_n: word input channel and row-result output channel.
interface matvec_n_if #(
  parameter int W  = 14,
  parameter int OW = 2*W
);
  logic                 input_valid;
  logic                 input_ready;
  logic signed [W-1:0]  input_data;
  logic                 new_matrix;
  logic                 output_valid;
  logic                 output_ready;
  logic signed [OW-1:0] output_data;

  modport slave (
    input  input_valid, input_data, new_matrix, output_ready,
    output input_ready, output_valid, output_data
  );

  modport master (
    output input_valid, input_data, new_matrix, output_ready,
    input  input_ready, output_valid, output_data
  );
endinterface

// File: rtl/matvec_n.sv
// N x N signed matrix-vector multiplier: streams in W (optional) and x, then
// emits one row result per handshake using a single serial MAC.
module matvec_n #(
  parameter int N   = 3,
  parameter int W   = 14,
  parameter int OW  = 2*W,
  parameter int SAT = 0
)(
  input  logic      gclk_i,
  input  logic      grst_ni,
  matvec_n_if.slave io
);
  localparam int AW = 2*W + $clog2(N) + 1;
  localparam int CW = $clog2(N*N);
  localparam int RW = $clog2(N);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_LOAD_X, S_MAC, S_OUT} state_t;

  state_t                  state_q, state_d;
  logic [N*N-1:0][W-1:0]   w_q;
  logic [N-1:0][W-1:0]     x_q;
  logic [CW-1:0]           ld_q;
  logic [RW-1:0]           row_q, col_q;
  logic signed [AW-1:0]    acc_q, acc_sum;
  logic signed [OW-1:0]    out_q, res;
  logic signed [2*W-1:0]   prod;
  logic [CW-1:0]           widx;
  logic in_acc, out_xfer, last_w, last_x, last_col, last_row;

  assign in_acc   = io.input_valid & io.input_ready;
  assign out_xfer = io.output_valid & io.output_ready;
  assign last_w   = (ld_q == CW'(N*N-1));
  assign last_x   = (ld_q == CW'(N-1));
  assign last_col = (col_q == RW'(N-1));
  assign last_row = (row_q == RW'(N-1));

  assign widx    = CW'(int'(row_q) * N + int'(col_q));
  assign prod    = $signed(w_q[widx]) * $signed(x_q[col_q]);
  assign acc_sum = acc_q + AW'(prod);

  // Accumulator is wide enough for any row sum, so clamping only matters
  // when the output is narrower than it.
  generate
    if (SAT != 0 && OW < AW) begin : g_sat
      localparam logic signed [AW-1:0] MAXV = {{(AW-OW+1){1'b0}}, {(OW-1){1'b1}}};
      localparam logic signed [AW-1:0] MINV = ~MAXV;
      assign res = (acc_sum > MAXV) ? OW'(MAXV) :
                   (acc_sum < MINV) ? OW'(MINV) : OW'(acc_sum);
    end else begin : g_wrap
      assign res = OW'(acc_sum);
    end
  endgenerate

  always_ff @(posedge gclk_i or negedge grst_ni) begin
    if (!grst_ni) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_acc) state_d = io.new_matrix ? S_LOAD_W : S_LOAD_X;
      S_LOAD_W: if (in_acc && last_w) state_d = S_LOAD_X;
      S_LOAD_X: if (in_acc && last_x) state_d = S_MAC;
      S_MAC:    if (last_col) state_d = S_OUT;
      S_OUT:    if (out_xfer) state_d = last_row ? S_IDLE : S_MAC;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io.input_ready  = 1'b0;
    io.output_valid = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD_W, S_LOAD_X: io.input_ready  = 1'b1;
      S_OUT:                      io.output_valid = 1'b1;
      default: ;
    endcase
  end

  assign io.output_data = out_q;

  always_ff @(posedge gclk_i or negedge grst_ni) begin
    if (!grst_ni) begin
      w_q   <= '0;
      x_q   <= '0;
      ld_q  <= '0;
      row_q <= '0;
      col_q <= '0;
      acc_q <= '0;
      out_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_acc) begin
          if (io.new_matrix) w_q[0] <= io.input_data;
          else               x_q[0] <= io.input_data;
          ld_q <= CW'(1);
        end
        S_LOAD_W: if (in_acc) begin
          w_q[ld_q] <= io.input_data;
          ld_q      <= last_w ? '0 : ld_q + CW'(1);
        end
        S_LOAD_X: if (in_acc) begin
          x_q[ld_q[RW-1:0]] <= io.input_data;
          if (last_x) begin
            ld_q  <= '0;
            row_q <= '0;
            col_q <= '0;
            acc_q <= '0;
          end else begin
            ld_q  <= ld_q + CW'(1);
          end
        end
        S_MAC: begin
          acc_q <= acc_sum;
          if (last_col) begin
            out_q <= res;
            col_q <= '0;
          end else begin
            col_q <= col_q + RW'(1);
          end
        end
        S_OUT: if (out_xfer) begin
          acc_q <= '0;
          row_q <= last_row ? '0 : row_q + RW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matvec_n.sv
// Bench for matvec_n: two instances (wrap / saturate) share one stimulus stream,
// checked every cycle against a transaction-level model of the matrix product.
module tb_matvec_n;
  localparam int N  = 4;
  localparam int W  = 14;
  localparam int OW = 28;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  matvec_n_if #(.W(W), .OW(OW)) if0 ();
  matvec_n_if #(.W(W), .OW(OW)) if1 ();

  matvec_n #(.N(N), .W(W), .OW(OW), .SAT(0)) dut0 (.gclk_i(gclk), .grst_ni(grst_n), .io(if0));
  matvec_n #(.N(N), .W(W), .OW(OW), .SAT(1)) dut1 (.gclk_i(gclk), .grst_ni(grst_n), .io(if1));

  typedef struct { bit nm; int d; } word_t;

  int      vectors = 0, miscompares = 0;
  longint  mat [N][N];
  longint  xv  [N];
  longint  yq0[$], yq1[$], got0[$], got1[$];
  word_t   wq[$];
  bit      busy, in_txn, loading_w, exp_ov;
  int      widx, xidx, cd, rows_left;
  int      gap_pct, stall_pct, force_stall;
  int      mbuf [N*N];
  int      xbuf [N];

  function automatic longint wrapv(longint v);
    longint t;
    t = v & ((64'sd1 <<< OW) - 1);
    if (t >= (64'sd1 <<< (OW-1))) t = t - (64'sd1 <<< OW);
    return t;
  endfunction

  function automatic longint satv(longint v);
    longint mx, mn;
    mx = (64'sd1 <<< (OW-1)) - 1;
    mn = -(64'sd1 <<< (OW-1));
    return (v > mx) ? mx : (v < mn) ? mn : v;
  endfunction

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit iv, input bit nm, input int d, input bit ordy);
    if0.input_valid = iv;  if1.input_valid = iv;
    if0.new_matrix  = nm;  if1.new_matrix  = nm;
    if0.input_data  = d[W-1:0]; if1.input_data = d[W-1:0];
    if0.output_ready = ordy; if1.output_ready = ordy;
  endtask

  task automatic model_clear();
    foreach (mat[i, j]) mat[i][j] = 0;
    foreach (xv[j]) xv[j] = 0;
    yq0.delete(); yq1.delete(); wq.delete();
    busy = 0; in_txn = 0; loading_w = 0; exp_ov = 0;
    cd = 0; widx = 0; xidx = 0; rows_left = 0;
  endtask

  // One clock: check outputs for this cycle, pick inputs, then advance the model
  // over the coming rising edge.
  task automatic step();
    bit iv, nm, ordy, nxt_ov, busy_old;
    int d;
    word_t w;
    longint s;
    @(negedge gclk);
    chk("input_ready_wrap", if0.input_ready, !busy);
    chk("input_ready_sat",  if1.input_ready, !busy);
    chk("output_valid_wrap", if0.output_valid, exp_ov);
    chk("output_valid_sat",  if1.output_valid, exp_ov);
    if (exp_ov) begin
      chk("y_wrap", if0.output_data, yq0[0]);
      chk("y_sat",  if1.output_data, yq1[0]);
    end
    iv = (wq.size() > 0) && ($urandom_range(99) >= gap_pct);
    nm = iv ? wq[0].nm : 1'($urandom_range(1));
    d  = iv ? wq[0].d  : int'($urandom);
    if (force_stall > 0) begin
      ordy = 0;
      if (exp_ov) force_stall--;
    end else begin
      ordy = ($urandom_range(99) >= stall_pct);
    end
    drive(iv, nm, d, ordy);

    busy_old = busy;
    nxt_ov = exp_ov;
    if (cd > 0) begin
      cd--;
      if (cd == 0) nxt_ov = 1;
    end
    if (exp_ov && ordy) begin
      got0.push_back(yq0.pop_front());
      got1.push_back(yq1.pop_front());
      nxt_ov = 0;
      rows_left--;
      if (rows_left > 0) cd = N;
      else busy = 0;
    end
    if (!busy_old && iv) begin
      w = wq.pop_front();
      if (!in_txn) begin
        in_txn = 1;
        if (w.nm) begin loading_w = 1; mat[0][0] = w.d; widx = 1; xidx = 0; end
        else      begin loading_w = 0; xv[0] = w.d; xidx = 1; end
      end else if (loading_w) begin
        mat[widx / N][widx % N] = w.d;
        widx++;
        if (widx == N*N) loading_w = 0;
      end else begin
        xv[xidx] = w.d;
        xidx++;
      end
      if (in_txn && !loading_w && xidx == N) begin
        for (int i = 0; i < N; i++) begin
          s = 0;
          for (int j = 0; j < N; j++) s += mat[i][j] * xv[j];
          yq0.push_back(wrapv(s));
          yq1.push_back(satv(s));
        end
        in_txn = 0; busy = 1; cd = N; rows_left = N;
      end
    end
    exp_ov = nxt_ov;
  endtask

  task automatic push_mat();
    wq.push_back('{1'b1, mbuf[0]});
    for (int k = 1; k < N*N; k++) wq.push_back('{1'($urandom_range(1)), mbuf[k]});
  endtask

  task automatic push_x(input bit first);
    wq.push_back('{first ? 1'b0 : 1'($urandom_range(1)), xbuf[0]});
    for (int k = 1; k < N; k++) wq.push_back('{1'($urandom_range(1)), xbuf[k]});
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((wq.size() > 0 || busy || in_txn) && k < budget) begin
      step();
      k++;
    end
    if (wq.size() > 0 || busy || in_txn) begin
      vectors++; miscompares++;
      $display("FAIL drain_timeout: got stuck after %0d cycles, expected completion", k);
      model_clear();
    end
  endtask

  task automatic expect_rows(input string name, input bit sat,
                             input longint e0, input longint e1, input longint e2, input longint e3);
    longint e [N];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, sat ? got1.size() : got0.size(), N);
    for (int i = 0; i < N; i++)
      if (i < (sat ? got1.size() : got0.size()))
        chk(name, sat ? got1[i] : got0[i], e[i]);
  endtask

  task automatic do_reset();
    @(negedge gclk);
    #2 grst_n = 1'b0;
    #1;
    chk("valid_in_reset", if0.output_valid, 0);
    chk("valid_in_reset_sat", if1.output_valid, 0);
    chk("ready_in_reset", if0.input_ready, 1);
    chk("data_in_reset", if0.output_data, 0);
    drive(0, 0, 0, 0);
    model_clear();
    got0.delete(); got1.delete();
    @(negedge gclk);
    grst_n = 1'b1;
  endtask

  initial begin
    gap_pct = 0; stall_pct = 0; force_stall = 0;
    drive(0, 0, 0, 0);
    model_clear();
    do_reset();
    repeat (3) step();

    // Before any matrix load the stored matrix is all zero.
    xbuf = '{1, 2, 3, 4}; push_x(1); drain(200);
    expect_rows("preload", 0, 0, 0, 0, 0);

    got0.delete(); got1.delete();
    mbuf = '{1,0,0,0, 0,1,0,0, 0,0,1,0, 0,0,0,1};
    push_mat(); xbuf = '{5, -7, 3, 9}; push_x(0); drain(300);
    expect_rows("identity", 0, 5, -7, 3, 9);

    got0.delete(); got1.delete();
    xbuf = '{1, 2, 3, 4}; push_x(1); drain(200);
    expect_rows("reuse", 0, 1, 2, 3, 4);

    got0.delete(); got1.delete();
    mbuf = '{1,2,3,4, 5,6,7,8, 9,10,11,12, 13,14,15,16};
    push_mat(); xbuf = '{1, 1, 1, 1}; push_x(0); drain(300);
    expect_rows("rowsum", 0, 10, 26, 42, 58);

    got0.delete(); got1.delete();
    force_stall = 10;
    xbuf = '{1, 2, 3, 4}; push_x(1); drain(300);
    expect_rows("backpressure", 0, 30, 70, 110, 150);

    got0.delete(); got1.delete();
    for (int k = 0; k < N*N; k++) mbuf[k] = -8192;
    push_mat(); xbuf = '{-8192, -8192, -8192, 0}; push_x(0); drain(300);
    expect_rows("pos_wrap", 0, -67108864, -67108864, -67108864, -67108864);
    expect_rows("pos_sat",  1, 134217727, 134217727, 134217727, 134217727);

    got0.delete(); got1.delete();
    xbuf = '{8191, 8191, 8191, 0}; push_x(1); drain(300);
    expect_rows("neg_wrap", 0, 67133440, 67133440, 67133440, 67133440);
    expect_rows("neg_sat",  1, -134217728, -134217728, -134217728, -134217728);

    // Reset while row 1 is accumulating, then reuse the (now cleared) matrix.
    got0.delete(); got1.delete();
    mbuf = '{1,2,3,4, 5,6,7,8, 9,10,11,12, 13,14,15,16};
    push_mat(); xbuf = '{1, 1, 1, 1}; push_x(0);
    for (int k = 0; k < 300 && got0.size() < 1; k++) step();
    chk("row0_before_reset", got0.size(), 1);
    step();
    do_reset();
    xbuf = '{4, 4, 4, 4}; push_x(1); drain(200);
    expect_rows("after_reset", 0, 0, 0, 0, 0);

    gap_pct = 20; stall_pct = 20;
    for (int t = 0; t < 1000; t++) begin
      got0.delete(); got1.delete();
      if ($urandom_range(99) < 30) begin
        for (int k = 0; k < N*N; k++) mbuf[k] = int'($urandom_range(16383)) - 8192;
        push_mat();
        for (int k = 0; k < N; k++) xbuf[k] = int'($urandom_range(16383)) - 8192;
        push_x(0);
      end else begin
        for (int k = 0; k < N; k++) xbuf[k] = int'($urandom_range(16383)) - 8192;
        push_x(1);
      end
      drain(400);
    end
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
